// File: rtl/divider_seq.sv
// divider_seq: multi-cycle restoring divider with channel select and
// unsigned/signed modes. It produces one quotient bit per enabled clock,
// uses a start/ready handshake and flags division by zero.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; the last result is held on the outputs
// S_CALC | one restoring step per enabled edge, WIDTH steps in total
// S_DONE | sign fix-up and result write. A zero divisor spends one extra
//        | edge here, so the start-to-ready latency is two edges.
module divider_seq #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 2,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      signed_mode,
  input  logic [CHANNELS*WIDTH-1:0] dividend_bus,
  input  logic [CHANNELS*WIDTH-1:0] divisor_bus,
  output logic [WIDTH-1:0]          quotient,
  output logic [WIDTH-1:0]          remainder,
  output logic                      busy,
  output logic                      ready,
  output logic                      div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_hold;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_ready;
  logic             r_dbz;

  logic [WIDTH-1:0] w_dvd_sel;
  logic [WIDTH-1:0] w_dvs_sel;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_dvs_zero;
  logic [WIDTH:0]   w_p_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_trial_ok;
  logic             w_cnt_last;

  // Channel mux; an out-of-range select falls back to channel 0.
  always_comb begin
    w_dvd_sel = dividend_bus[WIDTH-1:0];
    w_dvs_sel = divisor_bus[WIDTH-1:0];
    for (int k = 1; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        w_dvd_sel = dividend_bus[k*WIDTH +: WIDTH];
        w_dvs_sel = divisor_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Operand magnitudes. The sign flags are zero in unsigned mode, so the
  // fix-up in S_DONE needs no separate mode check. |MIN| wraps to MIN,
  // which is the correct unsigned magnitude.
  assign w_dvd_neg  = signed_mode & w_dvd_sel[WIDTH-1];
  assign w_dvs_neg  = signed_mode & w_dvs_sel[WIDTH-1];
  assign w_dvd_abs  = w_dvd_neg ? (~w_dvd_sel + 1'b1) : w_dvd_sel;
  assign w_dvs_abs  = w_dvs_neg ? (~w_dvs_sel + 1'b1) : w_dvs_sel;
  assign w_dvs_zero = (w_dvs_sel == '0);

  // One restoring step. P is always below B, which fits in WIDTH bits, so
  // the shifted P needs WIDTH+1 bits. The trial result then always fits a
  // WIDTH+1-bit signed value, and its top bit is the sign.
  assign w_p_sh     = {r_p, r_a[WIDTH-1]};
  assign w_trial    = w_p_sh - {1'b0, r_b};
  assign w_trial_ok = ~w_trial[WIDTH];
  assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. It only advances on enabled edges.
  always_comb begin
    w_state_nxt = r_state;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (w_cnt_last) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (!r_hold) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs. All of it holds while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      r_hold      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_dbz       <= 1'b0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // With a zero divisor A keeps the raw dividend, which is
            // returned unchanged as the remainder.
            r_a     <= w_dvs_zero ? w_dvd_sel : w_dvd_abs;
            r_b     <= w_dvs_abs;
            r_p     <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_zero  <= w_dvs_zero;
            r_hold  <= w_dvs_zero;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_dbz   <= 1'b0;
          end
        end
        S_CALC: begin
          r_p   <= w_trial_ok ? w_trial[WIDTH-1:0] : w_p_sh[WIDTH-1:0];
          r_a   <= {r_a[WIDTH-2:0], w_trial_ok};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          if (r_hold) begin
            r_hold <= 1'b0;
          end else begin
            if (r_zero) begin
              r_quotient  <= '1;
              r_remainder <= r_a;
              r_dbz       <= 1'b1;
            end else begin
              r_quotient  <= r_neg_q ? (~r_a + 1'b1) : r_a;
              r_remainder <= r_neg_r ? (~r_p + 1'b1) : r_p;
              r_dbz       <= 1'b0;
            end
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign ready       = r_ready;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed vectors for divider_seq (WIDTH=16, CHANNELS=3).
// The stimulus side queues the expected results. A monitor compares each
// result when ready rises. Latency, busy and reset checks are made inline.
module tb_divider_seq;

  localparam int W  = 16;
  localparam int CH = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [SW-1:0] sel;
  logic          signed_mode;
  logic [CH*W-1:0] dividend_bus;
  logic [CH*W-1:0] divisor_bus;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          busy;
  logic          ready;
  logic          div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  divider_seq #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .start        (start),
    .sel          (sel),
    .signed_mode  (signed_mode),
    .dividend_bus (dividend_bus),
    .divisor_bus  (divisor_bus),
    .quotient     (quotient),
    .remainder    (remainder),
    .busy         (busy),
    .ready        (ready),
    .div_by_zero  (div_by_zero)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry is consumed on every rising edge of ready.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", {16'h0, quotient}, {16'h0, e.q});
          chk("remainder", {16'h0, remainder}, {16'h0, e.r});
          chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.z});
        end
      end
      prev = ready;
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Issue one division and check latency and busy. With stall set, en
  // drops for 5 edges during CALC and junk starts with other operands
  // are pulsed while busy.
  task automatic do_div(input int ch, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic sm, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input int elat, input bit stall, input string nm);
    int  n;
    int  slot;
    bit  busy_ok;
    exp_t e;
    slot = (ch < CH) ? ch : 0;
    @(negedge clk);
    dividend_bus = 48'h7777_5555_3333;
    divisor_bus  = 48'h0009_0007_0003;
    dividend_bus[slot*W +: W] = dvd;
    divisor_bus[slot*W +: W]  = dvs;
    sel         = SW'(ch);
    signed_mode = sm;
    en          = 1'b1;
    start       = 1'b1;
    e.q = eq; e.r = er; e.z = ez;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    n       = 0;
    busy_ok = 1'b1;
    while (!ready && n < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (stall) begin
        en = !(n >= 4 && n < 9);
        if (n == 2 || n == 6 || n == 12) begin
          start        = 1'b1;
          dividend_bus = 48'hFFFF_FFFF_FFFF;
          divisor_bus  = 48'h0001_0001_0001;
        end else begin
          start = 1'b0;
        end
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    en    = 1'b1;
    start = 1'b0;
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_busy_window"}, {31'h0, busy_ok}, 32'd1);
    chk({nm, "_busy_after"}, {31'h0, busy}, 32'd0);
  endtask

  // Main stimulus.
  initial begin
    rst          = 1'b1;
    en           = 1'b1;
    start        = 1'b0;
    sel          = '0;
    signed_mode  = 1'b0;
    dividend_bus = '0;
    divisor_bus  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_quotient", {16'h0, quotient}, 32'h0);
    chk("rst_remainder", {16'h0, remainder}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    rst = 1'b0;

    do_div(0, 16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 17, 1'b0, "u_100_7");
    do_div(1, 16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 17, 1'b0, "s_m7_2");
    do_div(1, 16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 17, 1'b0, "s_7_m2");
    do_div(2, 16'hFF9C, 16'hFFF9, 1'b1, 16'h000E, 16'hFFFE, 1'b0, 17, 1'b0, "s_m100_m7");
    do_div(2, 16'hFF9C, 16'hFFF9, 1'b0, 16'h0000, 16'hFF9C, 1'b0, 17, 1'b0, "u_small_big");
    do_div(0, 16'd1234, 16'd0,    1'b0, 16'hFFFF, 16'd1234, 1'b1, 2,  1'b0, "dbz");
    do_div(1, 16'hFFF9, 16'd0,    1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 2,  1'b0, "dbz_signed");
    do_div(0, 16'd50,   16'd5,    1'b0, 16'd10,   16'd0,    1'b0, 17, 1'b0, "clear_dbz");
    do_div(1, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 17, 1'b0, "s_ovf");
    do_div(0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 17, 1'b0, "u_max_max");
    do_div(2, 16'd1000, 16'd3,    1'b0, 16'd333,  16'd1,    1'b0, 22, 1'b1, "stall");

    // Reset in the middle of CALC aborts the division without a result.
    @(negedge clk);
    dividend_bus = 48'h0000_1234_0000;
    divisor_bus  = 48'h0000_0005_0000;
    sel          = 2'd1;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_ready", {31'h0, ready}, 32'd0);
    chk("abort_quotient", {16'h0, quotient}, 32'd0);
    chk("abort_remainder", {16'h0, remainder}, 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("abort_no_result", {31'h0, ready}, 32'd0);

    do_div(3, 16'd65535, 16'd255, 1'b0, 16'd257, 16'd0, 1'b0, 17, 1'b0, "sel_oob");

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Parametrised multi-cycle restoring divider; successor to the fixed 16-bit, two-operand-pair divider in the arithmetic datapath.
- Selects one of CHANNELS operand pairs and produces a quotient and a remainder.
- Supports unsigned and signed (two's-complement) modes.
- Computes one quotient bit per clock, uses an explicit start/ready handshake, flags divide-by-zero, and can be stalled with en.

Parameters:
- WIDTH, 16: operand, quotient and remainder width in bits (must be ≥ 2).
- CHANNELS, 2: number of selectable dividend/divisor pairs (must be ≥ 1).
- SEL_W, derived (localparam): max(1, $clog2(CHANNELS)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; en=0 freezes all state.
- start  in  1  request a division; sampled only in IDLE with en=1.
- sel  in  SEL_W  channel index; sel ≥ CHANNELS selects channel 0.
- signed_mode  in  1  1 = two's-complement operands and results, 0 = unsigned.
- dividend_bus  in  CHANNELS*WIDTH  packed dividends; channel k occupies bits [k*WIDTH +: WIDTH].
- divisor_bus  in  CHANNELS*WIDTH  packed divisors, same packing as dividend_bus.
- quotient  out  WIDTH  registered result.
- remainder  out  WIDTH  registered result.
- busy  out  1  high while a division is in progress.
- ready  out  1  result valid; stays high until the next accepted start or reset.
- div_by_zero  out  1  the last result came from a zero divisor.

Behaviour:
- Reset (rst=1 at a clk edge, has priority over en):
  - state=IDLE; quotient=0, remainder=0, busy=0, ready=0, div_by_zero=0.
  - Aborts any division in progress; no result is produced.
- States: IDLE, CALC, DONE.
- en=0: all registers hold, including the iteration counter and outputs. Stall cycles add exactly one cycle each to latency.
- IDLE, on an edge with en=1 and start=1 (edge E0):
  - Latch the selected pair and signed_mode.
  - In signed mode, store |dividend| and |divisor| as WIDTH-bit unsigned values, plus neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - Set busy=1, ready=0, div_by_zero=0.
  - Next state is CALC, or DONE if the divisor is 0.
- start while busy=1 or in DONE is ignored. Operand inputs are not required to be stable after E0.
- CALC: one restoring step per enabled edge.
  - Shift {P, A} left by one.
  - Compute trial = P − B.
  - If the trial is non-negative: P = trial and the quotient LSB is 1. Otherwise P is kept and the LSB is 0.
  - After WIDTH steps (edges E1..E_WIDTH), go to DONE.
- DONE (one enabled edge): write quotient and remainder, set ready=1 and busy=0, return to IDLE.
  - Unsigned mode: quotient = A, remainder = P[WIDTH-1:0].
  - Signed mode: quotient = neg_q ? −A : A, and remainder = neg_r ? −P : P. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Divide-by-zero: quotient = all ones, remainder = original dividend (unmodified), div_by_zero=1.
  - Signed overflow (MIN / −1): quotient = MIN, remainder = 0, with no flag. This falls out of WIDTH-bit wrap.
- Latency with no stalls, measured from the start edge to ready=1:
  - Normal division: WIDTH+1 edges.
  - Divide-by-zero: 2 edges.
- A new start is accepted on the same edge that ready is first observed, or on any later edge. ready clears on that accepting edge.
- quotient and remainder hold their values until the next DONE or reset.

Test Plan:
- Unsigned, WIDTH=16, sel=0: dividend 100, divisor 7, start pulse → ready=1 exactly 17 edges later; quotient=14, remainder=2, div_by_zero=0; busy high for the 17-edge window.
- Signed, sel=1: dividend 0xFFF9 (−7), divisor 2 → quotient=0xFFFD (−3), remainder=0xFFFF (−1). Repeat with 7 / −2 → quotient=0xFFFD, remainder=0x0001.
- Divide-by-zero: dividend 1234, divisor 0 → ready after 2 edges; quotient=0xFFFF, remainder=1234, div_by_zero=1. The next valid division clears div_by_zero.
- Signed overflow: 0x8000 / 0xFFFF → quotient=0x8000, remainder=0. Also check 0xFFFF / 0xFFFF unsigned → quotient=1, remainder=0.
- Stall and ignored start: start 1000/3, drop en for 5 cycles mid-CALC, and pulse start with different operands while busy → ready after 22 edges with quotient=333, remainder=1; the second start has no effect.
- Reset mid-operation: assert rst at step 8 → next edge shows busy=0, ready=0, quotient=0, remainder=0. A subsequent 65535/255 gives quotient=257, remainder=0. With CHANNELS=3 and sel=3, channel 0 is used.
